// File: rtl/dma_seq_pkg.sv
// dma_seq_pkg: descriptor type, GN4124 DMA register map and sequencer state encoding.
// Revision 1.0
`default_nettype none

package dma_seq_pkg;

  typedef struct packed {
    logic [31:0] dev;
    logic [63:0] host;
    logic [31:0] len;
    logic        dir;
  } t_dma_desc;

  localparam logic [7:0] c_DMA_CTRL    = 8'h00;
  localparam logic [7:0] c_DMA_STAT    = 8'h04;
  localparam logic [7:0] c_DMA_CSTART  = 8'h08;
  localparam logic [7:0] c_DMA_HSTARTL = 8'h0C;
  localparam logic [7:0] c_DMA_HSTARTH = 8'h10;
  localparam logic [7:0] c_DMA_LEN     = 8'h14;
  localparam logic [7:0] c_DMA_NEXTL   = 8'h18;
  localparam logic [7:0] c_DMA_NEXTH   = 8'h1C;
  localparam logic [7:0] c_DMA_ATTRIB  = 8'h20;

  localparam logic [31:0] c_CTRL_START = 32'h0000_0001;
  localparam logic [31:0] c_CTRL_ABORT = 32'h0000_0002;
  localparam logic [31:0] c_STAT_DONE  = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4,
    S_ABORT = 3'd5
  } t_seq_state;

  // Programming writes are contiguous from CSTART, one word per index.
  function automatic logic [7:0] prog_offset(input logic [2:0] idx);
    return c_DMA_CSTART + {3'b000, idx, 2'b00};
  endfunction

  function automatic logic [31:0] prog_data(input t_dma_desc d, input logic [2:0] idx);
    case (idx)
      3'd0:    return d.dev;
      3'd1:    return d.host[31:0];
      3'd2:    return d.host[63:32];
      3'd3:    return d.len;
      3'd6:    return {31'b0, d.dir};
      default: return 32'h0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: synchronous FIFO of DMA descriptors with full/empty flags.
// Revision 1.0
`default_nettype none

module dma_desc_fifo
  import dma_seq_pkg::*;
#(
  parameter int g_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  t_dma_desc din_i,
  input  logic      pop_i,
  output t_dma_desc dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int             c_AW   = (g_DEPTH > 1) ? $clog2(g_DEPTH) : 1;
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(g_DEPTH);

  logic [c_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [c_AW:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;
  t_dma_desc       mem_q [g_DEPTH];

  assign full_o  = (cnt_q == c_FULL);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/dma_xfer_sequencer.sv
// dma_xfer_sequencer: queues DMA descriptors and drives the GN4124 DMA engine over Wishbone.
// Revision 1.0
`default_nettype none

module dma_xfer_sequencer
  import dma_seq_pkg::*;
#(
  parameter logic [31:0] g_DMA_BASE    = 32'h0000_00C0,
  parameter int          g_FIFO_DEPTH  = 4,
  parameter int          g_TIMEOUT_CYC = 125000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic [31:0] desc_dev_i,
  input  logic [63:0] desc_host_i,
  input  logic [31:0] desc_len_i,
  input  logic        desc_dir_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        dma_done_i,
  output logic        busy_o,
  output logic        xfer_done_o,
  output logic        xfer_err_o,
  output logic [15:0] xfer_cnt_o
);

  localparam logic [31:0] c_TMO_LAST = 32'(g_TIMEOUT_CYC - 1);

  t_seq_state  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        gap_q, gap_d, abort_pend_q, abort_pend_d;
  logic [31:0] tmo_q, tmo_d;
  t_dma_desc   desc_q, desc_d, fifo_head, push_desc;
  logic        done_q, done_d, xerr_q, xerr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fifo_full, fifo_empty, fifo_pop, wb_active;
  logic [7:0]  wb_off;
  logic [31:0] wb_dat;

  assign push_desc = '{dev: desc_dev_i, host: desc_host_i, len: desc_len_i, dir: desc_dir_i};

  dma_desc_fifo #(.g_DEPTH(g_FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (desc_valid_i),
    .din_i   (push_desc),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // gap_q marks the mandatory cyc-low cycle that follows every completed write.
  always_comb begin
    wb_active = ~gap_q & (state_q inside {S_PROG, S_START, S_ACK, S_ABORT});
    wb_off    = c_DMA_CTRL;
    wb_dat    = '0;
    case (state_q)
      S_PROG:  begin wb_off = prog_offset(idx_q); wb_dat = prog_data(desc_q, idx_q); end
      S_START: wb_dat = c_CTRL_START;
      S_ACK:   begin wb_off = c_DMA_STAT; wb_dat = c_STAT_DONE; end
      S_ABORT: wb_dat = c_CTRL_ABORT;
      default: ;
    endcase
  end

  assign wb_cyc_o     = wb_active;
  assign wb_stb_o     = wb_active;
  assign wb_we_o      = wb_active;
  assign wb_sel_o     = {4{wb_active}};
  assign wb_adr_o     = wb_active ? (g_DMA_BASE + {24'b0, wb_off}) : '0;
  assign wb_dat_o     = wb_active ? wb_dat : '0;
  assign desc_ready_o = ~fifo_full;
  assign busy_o       = (state_q != S_IDLE) | ~fifo_empty;
  assign xfer_done_o  = done_q;
  assign xfer_err_o   = xerr_q;
  assign xfer_cnt_o   = cnt_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    abort_pend_d = abort_pend_q;
    tmo_d        = tmo_q;
    desc_d       = desc_q;
    done_d       = 1'b0;
    xerr_d       = 1'b0;
    fifo_pop     = 1'b0;
    if (gap_q) begin
      gap_d = 1'b0;
      if (abort_pend_q) begin
        abort_pend_d = 1'b0;
        state_d      = S_ABORT;
      end else begin
        case (state_q)
          S_PROG:  if (idx_q == 3'd6) begin idx_d = '0; state_d = S_START; end
                   else idx_d = idx_q + 3'd1;
          S_START: begin tmo_d = '0; state_d = S_WAIT; end
          default: state_d = S_IDLE;
        endcase
      end
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) begin
          fifo_pop = 1'b1;
          desc_d   = fifo_head;
          idx_d    = '0;
          state_d  = S_PROG;
        end
        // Done is checked before the timeout so a simultaneous arrival still completes.
        S_WAIT: if (dma_done_i)                state_d = S_ACK;
                else if (tmo_q == c_TMO_LAST) state_d = S_ABORT;
                else                          tmo_d   = tmo_q + 32'd1;
        S_PROG, S_START, S_ACK, S_ABORT: if (wb_ack_i | wb_err_i) begin
          gap_d = 1'b1;
          if (state_q == S_ABORT)   xerr_d       = 1'b1;
          else if (wb_err_i)        abort_pend_d = 1'b1;
          else if (state_q == S_ACK) done_d      = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    cnt_d = cnt_q + {15'b0, done_d};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      gap_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      tmo_q        <= '0;
      desc_q       <= '0;
      done_q       <= 1'b0;
      xerr_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      abort_pend_q <= abort_pend_d;
      tmo_q        <= tmo_d;
      desc_q       <= desc_d;
      done_q       <= done_d;
      xerr_q       <= xerr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

`default_nettype wire
